// File: rtl/lr_pkg.sv
// lr_pkg: FSM states and fixed-point helpers for the SGD trainer.
// LR_SATURATE_EN: sat() clamps to the signed range, else it wraps.
package lr_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PRED,
    S_ERR, S_UPD, S_NEXT, S_DONE
  } state_e;

  localparam int DW_DEF   = 16;
  localparam int FRAC_DEF = 8;
  localparam int SAT_W    = 64;

  // Reduce a wide signed value to dw bits, sign-extended to SAT_W.
  function automatic logic signed [SAT_W-1:0] sat(
    input logic signed [SAT_W-1:0] v,
    input int                      dw
  );
`ifdef LR_SATURATE_EN
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
`else
    return (v <<< (SAT_W - dw)) >>> (SAT_W - dw);
`endif
  endfunction

endpackage

// File: rtl/lr_mac.sv
// lr_mac: shared signed DW x DW multiplier for prediction and update.
// upd_o = sat(c + (a*b >>> FRAC)); prod_o is the raw full product.
module lr_mac
  import lr_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  input  logic signed [DW-1:0]   c_i,
  output logic signed [2*DW-1:0] prod_o,
  output logic signed [DW-1:0]   upd_o
);

  localparam int PW = 2 * DW;

  logic signed [SAT_W-1:0] sum;

  // Full-width product, then scaled accumulate onto c_i.
  always_comb begin
    prod_o = PW'(a_i) * PW'(b_i);
    sum    = SAT_W'(c_i) + (SAT_W'(prod_o) >>> FRAC);
    upd_o  = DW'(sat(sum, DW));
  end

endmodule

// File: rtl/lr_sgd_trainer.sv
// lr_sgd_trainer: streaming SGD linear-regression trainer, one MAC.
// LR_SATURATE_EN (in lr_pkg) selects clamping instead of wrapping.
module lr_sgd_trainer
  import lr_pkg::*;
#(
  parameter int N_FEAT   = 6,
  parameter int N_DP     = 6,
  parameter int DP_AW    = 4,
  parameter int DW       = DW_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int LR_SHIFT = 7,
  parameter int EPOCH_W  = 8,
  parameter logic [DW-1:0] WT_INIT = DW'(16'h0040)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic                     init_wt,
  input  logic [EPOCH_W-1:0]       epochs_cfg,
  output logic                     mem_rd,
  output logic [DP_AW-1:0]         mem_addr,
  input  logic                     mem_valid,
  input  logic [(N_FEAT+1)*DW-1:0] mem_data,
  output logic                     busy,
  output logic                     done,
  output logic [(N_FEAT+1)*DW-1:0] wt_flat
);

  localparam int AW = 2 * DW + 4;
  localparam int KW = 5;
  localparam logic [KW-1:0]    K_LAST = KW'(N_FEAT - 1);
  localparam logic [DP_AW-1:0] A_LAST = DP_AW'(N_DP - 1);

  state_e                  state_q;
  logic [EPOCH_W-1:0]      ep_q, ep_cnt_q, ep_d;
  logic [DP_AW-1:0]        addr_q;
  logic [KW-1:0]           k_q;
  logic signed [DW-1:0]    w_q [N_FEAT+1];
  logic signed [DW-1:0]    x_q [N_FEAT];
  logic signed [DW-1:0]    y_q, err_q, err_d;
  logic signed [DW-1:0]    err_sat, ycap, w0_d;
  logic signed [AW-1:0]    acc_q;
  logic signed [SAT_W-1:0] ycap_sum, diff, w0_sum;
  logic                    mem_rd_q, busy_q, done_q;
  logic signed [DW-1:0]    mac_a, mac_b, mac_c, mac_upd;
  logic signed [2*DW-1:0]  mac_prod;
  int unsigned             kk;

  // Route the current feature and weight (or err in UPD) to the MAC.
  always_comb begin
    kk    = 32'(k_q);
    mac_a = x_q[kk];
    mac_c = w_q[kk+1];
    mac_b = (state_q == S_UPD) ? err_q : w_q[kk+1];
  end

  lr_mac #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_mac (
    .a_i    (mac_a),
    .b_i    (mac_b),
    .c_i    (mac_c),
    .prod_o (mac_prod),
    .upd_o  (mac_upd)
  );

  // Prediction, scaled error, bias update and next epoch count.
  always_comb begin
    ycap_sum = SAT_W'(w_q[0]) + SAT_W'(acc_q >>> FRAC);
    ycap     = DW'(sat(ycap_sum, DW));
    diff     = SAT_W'(y_q) - SAT_W'(ycap);
    err_sat  = DW'(sat(diff, DW));
    err_d    = err_sat >>> LR_SHIFT;
    w0_sum   = SAT_W'(w_q[0]) + SAT_W'(err_q);
    w0_d     = DW'(sat(w0_sum, DW));
    ep_d     = ep_q + EPOCH_W'(1);
  end

  // Weights are registered state; flatten them onto the output bus.
  always_comb begin
    wt_flat = '0;
    for (int i = 0; i <= N_FEAT; i++) wt_flat[i*DW +: DW] = w_q[i];
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Training sequencer with registered handshake outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ep_q     <= '0;
      ep_cnt_q <= '0;
      addr_q   <= A_LAST;
      k_q      <= '0;
      y_q      <= '0;
      err_q    <= '0;
      acc_q    <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i <= N_FEAT; i++) w_q[i] <= WT_INIT;
      for (int i = 0; i < N_FEAT; i++) x_q[i] <= '0;
    end else begin
      mem_rd_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ep_cnt_q <= epochs_cfg;
            ep_q     <= '0;
            addr_q   <= A_LAST;
            if (init_wt)
              for (int i = 0; i <= N_FEAT; i++) w_q[i] <= WT_INIT;
            if (epochs_cfg == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_FETCH;
              busy_q   <= 1'b1;
              mem_rd_q <= 1'b1;
            end
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          if (mem_valid) begin
            y_q <= mem_data[DW-1:0];
            for (int i = 0; i < N_FEAT; i++)
              x_q[i] <= mem_data[(i+1)*DW +: DW];
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= S_PRED;
          end
        end
        S_PRED: begin
          acc_q <= acc_q + AW'(mac_prod);
          if (k_q == K_LAST) begin
            k_q     <= '0;
            state_q <= S_ERR;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_ERR: begin
          err_q   <= err_d;
          k_q     <= '0;
          state_q <= S_UPD;
        end
        S_UPD: begin
          w_q[kk+1] <= mac_upd;
          if (k_q == '0) w_q[0] <= w0_d;
          if (k_q == K_LAST) begin
            k_q     <= '0;
            state_q <= S_NEXT;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_NEXT: begin
          if (addr_q == '0) begin
            ep_q   <= ep_d;
            addr_q <= A_LAST;
            if (ep_d == ep_cnt_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= S_FETCH;
              mem_rd_q <= 1'b1;
            end
          end else begin
            addr_q   <= addr_q - DP_AW'(1);
            state_q  <= S_FETCH;
            mem_rd_q <= 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lr_sgd_trainer.sv
// tb_lr_sgd_trainer: directed and random training runs checked
// against an integer-arithmetic SGD reference model.
module tb_lr_sgd_trainer;

  localparam int NF = 6;
  localparam int ND = 6;
  localparam int DW = 16;
  localparam int WW = (NF + 1) * DW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          init_wt = 1'b0;
  logic [7:0]    epochs_cfg = '0;
  logic          mem_rd;
  logic [3:0]    mem_addr;
  logic          mem_valid = 1'b0;
  logic [WW-1:0] mem_data = '0;
  logic          busy;
  logic          done;
  logic [WW-1:0] wt_flat;

  int checks = 0;
  int errors = 0;
  int ndone = 0;
  int lat = 0;
  int pend = 0;
  bit noise = 1'b0;
  logic [3:0] paddr = '0;
  logic [3:0] aq [$];

  logic [15:0] mx [ND][NF];
  logic [15:0] my [ND];
  longint      mw [NF+1];

  lr_sgd_trainer dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .init_wt    (init_wt),
    .epochs_cfg (epochs_cfg),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data),
    .busy       (busy),
    .done       (done),
    .wt_flat    (wt_flat)
  );

  always #5 CLK = ~CLK;

  function automatic logic [WW-1:0] pack(input logic [3:0] a);
    logic [WW-1:0] d;
    int ai;
    ai = int'(a);
    d[15:0] = my[ai];
    for (int k = 0; k < NF; k++) d[(k+1)*16 +: 16] = mx[ai][k];
    return d;
  endfunction

  // Data-point RAM with programmable latency and stray valid noise.
  always @(posedge CLK) begin
    if (done === 1'b1) ndone++;
    mem_valid <= 1'b0;
    if (mem_rd === 1'b1) begin
      aq.push_back(mem_addr);
      pend  <= lat;
      paddr <= mem_addr;
      if (lat == 0) begin
        mem_valid <= 1'b1;
        mem_data  <= pack(mem_addr);
      end
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        mem_valid <= 1'b1;
        mem_data  <= pack(paddr);
      end
    end else if (noise) begin
      mem_valid <= 1'($urandom_range(0, 1));
      mem_data  <= WW'({$urandom, $urandom, $urandom, $urandom});
    end
  end

  task automatic check(input string tag, input logic [WW-1:0] obs,
                       input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint satm(longint v);
`ifdef LR_SATURATE_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    longint t;
    t = v & 64'hFFFF;
    if (t >= 32768) t = t - 65536;
    return t;
`endif
  endfunction

  function automatic longint sx(logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Plain SGD over the RAM contents, points ND-1 down to 0.
  task automatic model_train(input int e, input bit init);
    longint acc, ycap, err;
    if (init) for (int i = 0; i <= NF; i++) mw[i] = 64;
    for (int ep = 0; ep < e; ep++) begin
      for (int p = ND - 1; p >= 0; p--) begin
        acc = 0;
        for (int k = 0; k < NF; k++) acc += sx(mx[p][k]) * mw[k+1];
        ycap = satm(mw[0] + (acc >>> 8));
        err = satm(sx(my[p]) - ycap) >>> 7;
        mw[0] = satm(mw[0] + err);
        for (int k = 0; k < NF; k++)
          mw[k+1] = satm(mw[k+1] + ((sx(mx[p][k]) * err) >>> 8));
      end
    end
  endtask

  function automatic logic [WW-1:0] mflat();
    logic [WW-1:0] d;
    for (int i = 0; i <= NF; i++) d[i*16 +: 16] = 16'(mw[i]);
    return d;
  endfunction

  function automatic logic [WW-1:0] flat3(logic [15:0] a, logic [15:0] b,
                                          logic [15:0] c);
    logic [WW-1:0] d;
    d[15:0]  = a;
    d[31:16] = b;
    for (int i = 2; i <= NF; i++) d[i*16 +: 16] = c;
    return d;
  endfunction

  task automatic fill_mem(input logic [15:0] xv, input logic [15:0] yv);
    for (int p = 0; p < ND; p++) begin
      my[p] = yv;
      for (int k = 0; k < NF; k++) mx[p][k] = xv;
    end
  endtask

  task automatic rand_mem();
    for (int p = 0; p < ND; p++) begin
      my[p] = 16'($urandom);
      for (int k = 0; k < NF; k++) mx[p][k] = 16'($urandom);
    end
  endtask

  task automatic run_train(input string tag, input int e, input bit init,
                           input int lt, input bit poke);
    int cyc;
    int n0;
    lat = lt;
    n0 = ndone;
    @(negedge CLK);
    start = 1'b1;
    init_wt = init;
    epochs_cfg = 8'(e);
    @(negedge CLK);
    start = 1'b0;
    init_wt = 1'b0;
    epochs_cfg = 8'($urandom);
    cyc = 1;
    check({tag, "_busy"}, WW'(busy), WW'(e != 0));
    while (done !== 1'b1 && cyc < 4000) begin
      if (poke) begin
        start = (cyc == 20);
        init_wt = start;
      end
      @(negedge CLK);
      cyc++;
    end
    check({tag, "_cyc"}, WW'(cyc), WW'(1 + e * ND * (2 * NF + 4 + lt)));
    check({tag, "_busy_at_done"}, WW'(busy), '0);
    model_train(e, init);
    check({tag, "_wt"}, wt_flat, mflat());
    @(negedge CLK);
    check({tag, "_pulse"}, WW'(done), '0);
    check({tag, "_ndone"}, WW'(ndone - n0), WW'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] ov;
    logic [47:0] ev;
    int cyc;
    int n0;

    fill_mem(16'h0000, 16'h0000);
    for (int i = 0; i <= NF; i++) mw[i] = 64;

    repeat (2) @(negedge CLK);
    check("rst_busy", WW'(busy), '0);
    check("rst_done", WW'(done), '0);
    check("rst_rd", WW'(mem_rd), '0);
    check("rst_addr", WW'(mem_addr), WW'(5));
    check("rst_wt", wt_flat, flat3(16'h40, 16'h40, 16'h40));
    RST = 1'b0;
    @(negedge CLK);
    check("idle_busy", WW'(busy), '0);

    run_train("ep0", 0, 1'b1, 0, 1'b0);
    check("ep0_const", wt_flat, flat3(16'h40, 16'h40, 16'h40));

    fill_mem(16'h0000, 16'h0041);
    my[5] = 16'h0100;
    run_train("bias_pt", 1, 1'b1, 0, 1'b0);
    check("bias_const", wt_flat, flat3(16'h41, 16'h40, 16'h40));

    mx[5][0] = 16'h0100;
    run_train("w1_pt", 1, 1'b1, 0, 1'b0);
    check("w1_const", wt_flat, flat3(16'h41, 16'h41, 16'h40));

    rand_mem();
    aq.delete();
    run_train("two_ep", 2, 1'b1, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      ov[i*4 +: 4] = (i < aq.size()) ? aq[i] : 4'hF;
      ev[i*4 +: 4] = 4'(5 - (i % 6));
    end
    check("addr_cnt", WW'(aq.size()), WW'(12));
    check("addr_seq", WW'(ov), WW'(ev));

    fill_mem(16'h7FFF, 16'h8000);
    run_train("sat", 1, 1'b1, 0, 1'b0);
`ifdef LR_SATURATE_EN
    check("sat_w0", WW'(wt_flat[15:0]), WW'(16'hFF40));
`endif

    noise = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rand_mem();
      run_train($sformatf("rnd%0d", r), $urandom_range(1, 3),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b1);
    end

    noise = 1'b0;
    lat = 0;
    @(negedge CLK);
    start = 1'b1;
    init_wt = 1'b0;
    epochs_cfg = 8'd1;
    @(negedge CLK);
    start = 1'b0;
    cyc = 1;
    while (cyc < 44) begin
      @(negedge CLK);
      cyc++;
    end
    n0 = ndone;
    RST = 1'b1;
    #1;
    check("abort_busy", WW'(busy), '0);
    check("abort_done", WW'(done), '0);
    check("abort_rd", WW'(mem_rd), '0);
    check("abort_addr", WW'(mem_addr), WW'(5));
    check("abort_wt", wt_flat, flat3(16'h40, 16'h40, 16'h40));
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("abort_nodone", WW'(ndone - n0), '0);
    for (int i = 0; i <= NF; i++) mw[i] = 64;
    run_train("post_rst", 1, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lr_sgd_trainer.md
# lr_sgd_trainer

Parametrised, fully clocked stochastic-gradient-descent linear-regression trainer; successor to the fixed 6-feature/6-point trainer. It streams data points from an external data-point RAM through a request/valid read port, predicts with one shared fixed-point MAC, and updates bias and weights per point. It runs a run-time-programmable number of epochs under a start/done handshake and exposes the trained weights on a flat output bus.

## Interface
- N_FEAT, 6, number of features (1..16)
- N_DP, 6, data points per epoch (1..2^DP_AW)
- DP_AW, 4, data-point address width
- DW, 16, signed data/weight width
- FRAC, 8, fractional bits (Q(DW-FRAC).FRAC)
- LR_SHIFT, 7, learning rate = 2^-LR_SHIFT
- EPOCH_W, 8, epoch counter width
- WT_INIT, 16'h0040, initial value of bias and every weight

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  begin training run; sampled in IDLE only
- init_wt  in  1  with start: reload all weights to WT_INIT before training
- epochs_cfg  in  EPOCH_W  epochs to run, latched at start
- mem_rd  out  1  read request, one-cycle pulse
- mem_addr  out  DP_AW  data-point address
- mem_valid  in  1  read data valid (≥1 cycle after mem_rd)
- mem_data  in  (N_FEAT+1)*DW  [DW-1:0]=y, slice k+1 = feature x[k]
- busy  out  1  high from cycle after start accepted until done
- done  out  1  one-cycle pulse at run end
- wt_flat  out  (N_FEAT+1)*DW  slice 0 = bias w0, slice k+1 = w[k+1]

## Operation
- States: IDLE, FETCH, WAIT, PRED, ERR, UPD, NEXT, DONE.
- IDLE: start=1 latches epochs_cfg; if init_wt, all weights ← WT_INIT; addr ← N_DP-1, epoch ← 0; epochs_cfg=0 → DONE, else FETCH.
- FETCH: mem_rd=1 with mem_addr; → WAIT.
- WAIT: hold until mem_valid; capture y and x[] into registers; acc ← 0; → PRED.
- PRED: N_FEAT cycles, k=0..N_FEAT-1: acc += x[k]*w[k+1] (full 2*DW product, accumulator 2*DW+4 bits).
- ERR: y_cap = sat(w0 + (acc >>> FRAC)); err = sat(y − y_cap) >>> LR_SHIFT (arithmetic).
- UPD: N_FEAT cycles; cycle k: w[k+1] ← sat(w[k+1] + ((x[k]*err) >>> FRAC)); cycle 0 also w0 ← sat(w0 + err).
- NEXT: addr==0 → epoch+1, addr ← N_DP-1; else addr−1. epoch == latched count → DONE, else FETCH.
- DONE: done=1 for one cycle; → IDLE.
- Points visited N_DP-1 down to 0 each epoch.
- start while busy ignored; init_wt ignored without start.
- mem_valid outside WAIT ignored.

## Timing
- Reset: state IDLE, busy=0, done=0, mem_rd=0, mem_addr=N_DP-1, all weights WT_INIT, epoch=0.
- RST mid-run aborts immediately; no done pulse; weights return to WT_INIT.
- Per point, zero-wait memory (mem_valid the cycle after mem_rd): 2*N_FEAT+4 cycles.
- start sampled at edge t → busy=1 and FETCH at t+1; done at t+1+E*N_DP*(2*N_FEAT+4); busy=0 same cycle as done.
- epochs_cfg=0: done at t+1, weights untouched (except init_wt reload).
- wt_flat is registered; final weights are stable when done is high.

## Configuration
- LR_SATURATE_EN defined: every sat() clamps to [−2^(DW-1), 2^(DW-1)−1].
- Undefined: sat() truncates to DW bits (two's-complement wrap), matching the previous generation.

## Structure
- Package lr_pkg: state enum, fixed-point width/FRAC constants, sat/truncate function selected by LR_SATURATE_EN.
- Sub-module lr_mac: shared signed DW×DW multiplier with >>>FRAC scaling and sat, used in PRED and UPD (replaces the per-feature bw_mul array).

## Test plan
- epochs_cfg=0, init_wt=1 → done one cycle after start; every wt_flat slice 0x0040.
- 1 epoch, N_DP=1, all x=0, y=0x0100 → y_cap=0x0040, err=0x0001, w0=0x0041, other weights 0x0040.
- 1 epoch, N_DP=1, x[0]=0x0100, others 0, y=0x0100 → y_cap=0x0080, err=0x0001, w0=0x0041, w1=0x0041.
- Defaults, epochs_cfg=2, zero-wait memory → done exactly 192 cycles after busy rises; mem_addr sequence 5..0 twice.
- All x=0x7FFF, y=0x8000 → with LR_SATURATE_EN: y_cap=0x7FFF, err=0xFF00; without: wrapped values match the reference model.
- RST asserted during UPD of point 3 → next cycle IDLE, busy=0, no done, weights 0x0040; new start runs normally.
